mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- Memory-access stage of the 5-stage RISC-V pipeline; sits between the EX/MEM pipeline register and the MEM/WB register.
- Decodes load/store from the instruction and drives a req/gnt/rvalid data-memory handshake.
- Performs byte-lane alignment and sign/zero extension, and selects the writeback value (ALU, load data, PC+4).
- Drives mem_rd, mem_inst and mem_regWEn into MEM/WB; asserts stall to freeze the upstream pipeline enables while an access is outstanding.

Parameters:
- TIMEOUT, 16, maximum cycles spent in REQ plus WAIT_R before the access is abandoned with bus_err.
- TCNT_W, 5, width of the timeout counter; must satisfy 2^TCNT_W > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  EX/MEM slot holds a real instruction (0 = bubble).
- in_alu  in  32  ALU result / effective address.
- in_rs2  in  32  store data.
- in_pc  in  32  instruction PC.
- in_inst  in  32  instruction word.
- in_regWEn  in  1  register write enable from decode.
- in_wbSel  in  2  writeback select: 0 ALU, 1 load, 2 PC+4, 3 reserved (treated as ALU).
- dmem_req  out  1  memory request, registered.
- dmem_we  out  1  1 = store.
- dmem_addr  out  32  word-aligned address {addr[31:2],2'b00}.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-shifted store data.
- dmem_gnt  in  1  request accepted.
- dmem_rvalid  in  1  load data valid.
- dmem_rdata  in  32  load data.
- mem_rd  out  32  writeback value to MEM/WB.
- mem_inst  out  32  instruction to MEM/WB.
- mem_regWEn  out  1  write enable to MEM/WB.
- stall  out  1  1 = hold all upstream pipeline registers, including MEM/WB enable.
- misaligned  out  1  1-cycle pulse on a misaligned access.
- bus_err  out  1  1-cycle pulse on timeout.

Behaviour:
- Decode: opcode in_inst[6:0] = 0000011 is a load, 0100011 is a store; funct3 = in_inst[14:12].
- Mem op means in_valid & (load | store).
- Reset (reset = 0, asynchronous): state to IDLE; dmem_req, dmem_we, misaligned and bus_err to 0; dmem_addr, dmem_be, dmem_wdata, captured address/funct3 and load data to 0; timeout counter to 0. Reset mid-access aborts immediately and drops dmem_req; a late gnt/rvalid arriving in IDLE is ignored.
- States:
  - IDLE: non-mem op or bubble → pass-through, stall = 0. Aligned mem op → latch addr[1:0] and funct3, drive dmem_* next edge, go to REQ; stall = 1 combinationally this cycle. Misaligned (half with addr[0] = 1; word with addr[1:0] ≠ 0) → no request, stay IDLE, stall = 0, mem_regWEn = 0, misaligned = 1 this cycle.
  - REQ: dmem_req = 1, held with stable addr/be/wdata until dmem_gnt. On gnt: store → DONE; load → WAIT_R. A gnt and rvalid arriving in the same cycle capture the data and go to DONE.
  - WAIT_R: dmem_req = 0; on dmem_rvalid capture dmem_rdata and go to DONE.
  - DONE: stall = 0; outputs valid; MEM/WB captures this edge; next state is IDLE.
- Timeout: counter clears on entering REQ and increments in REQ/WAIT_R. When it reaches TIMEOUT: go to DONE with mem_regWEn = 0, bus_err = 1 for one cycle, dmem_req = 0.
- Store lanes:
  - SB: be = 0001 << a[1:0], wdata = byte replicated ×4.
  - SH: be = 0011 << {a[1],1'b0}, wdata = half replicated ×2.
  - SW: be = 1111.
- Load extract: byte/half selected by the captured a[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW takes the full word. funct3 values 011, 110 and 111 are treated as LW.
- Outputs: mem_rd from in_wbSel (ALU | extended load | in_pc + 4, 32-bit wrap). mem_inst = in_inst. mem_regWEn = in_valid & in_regWEn, and is 0 on misaligned or timeout. Stores never write registers, because decode clears in_regWEn.
- Latency: non-mem op 0 extra cycles. Store ≥ 2 stall cycles; load ≥ 3 stall cycles (IDLE, REQ, WAIT_R) with zero memory wait states.
- Upstream holds in_* stable while stall = 1.

Decomposition:
- Shared package:
  - Opcode constants LOAD/STORE.
  - funct3 encodings LB/LH/LW/LBU/LHU/SB/SH/SW.
  - wbSel encodings WB_ALU/WB_MEM/WB_PC4.
  - State encoding IDLE/REQ/WAIT_R/DONE.
- One natural sub-module: load_extend (combinational: rdata, a[1:0], funct3 → 32-bit extended value), reusable by the verification model.

Test Plan:
- ADD passthrough: in_alu = 0x00000005, wbSel = 0, regWEn = 1 → same cycle mem_rd = 5, mem_regWEn = 1, stall = 0, dmem_req never asserted.
- LB at addr 0x103, gnt immediate, rvalid 1 cycle later with rdata = 0x80AABBCC → dmem_addr = 0x100, stall high 3 cycles, DONE mem_rd = 0xFFFFFF80. Repeat with LBU → mem_rd = 0x00000080.
- SH at addr 0x202, rs2 = 0x1234ABCD, gnt delayed 3 cycles → dmem_req held 4 cycles with be = 1100, wdata = 0xABCDABCD, dmem_we = 1; then DONE with mem_regWEn = 0.
- LW at addr 0x006 → no dmem_req, misaligned pulse, mem_regWEn = 0, stall = 0.
- LW with gnt never asserted, TIMEOUT = 16 → bus_err pulse after 16 cycles in REQ, mem_regWEn = 0, return to IDLE.
- Reset asserted in WAIT_R → dmem_req/stall 0 immediately; a later rvalid is ignored; a following JAL with wbSel = 2, pc = 0x40 gives mem_rd = 0x44.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the memory-access stage: opcodes, funct3, writeback select, FSM states.
package mem_access_stage_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReq   = 2'd1,
    StWaitR = 2'd2,
    StDone  = 2'd3
  } state_e;

  // Access size lives in funct3[1:0] for both loads and stores: 00 byte, 01 half, else word.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic bad;
    unique case (funct3[1:0])
      2'b00:   bad = 1'b0;
      2'b01:   bad = addr_lo[0];
      default: bad = (addr_lo != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_stage_load_extend.sv
// Load data extraction: selects the addressed byte/half and sign- or zero-extends it.
module mem_access_stage_load_extend
  import mem_access_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane out of the returned word
  always_comb begin
    unique case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // Extend to 32 bits; unlisted funct3 codes behave as LW
  always_comb begin
    unique case (funct3)
      F3_LB:   ext = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   ext = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  ext = {24'h000000, byte_sel};
      F3_LHU:  ext = {16'h0000, half_sel};
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: decodes load/store, runs the req/gnt/rvalid handshake, stalls the pipe while
// an access is in flight and selects the writeback value for MEM/WB.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TCNT_W  = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_alu,
  input  logic [31:0] in_rs2,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_inst,
  input  logic        in_regWEn,
  input  logic [1:0]  in_wbSel,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] mem_rd,
  output logic [31:0] mem_inst,
  output logic        mem_regWEn,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_err
);

  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [1:0]        alo_q;
  logic [2:0]        f3_q;
  logic [31:0]       rdata_q;
  logic              req_q, we_q, bus_err_q;
  logic [31:0]       addr_q, wdata_q;
  logic [3:0]        be_q;

  logic        is_load, is_store, mem_op, bad_align;
  logic        launch, capture, timeout;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [31:0] load_val;

  assign is_load   = (in_inst[6:0] == OP_LOAD);
  assign is_store  = (in_inst[6:0] == OP_STORE);
  assign mem_op    = in_valid & (is_load | is_store);
  assign bad_align = is_misaligned(in_inst[14:12], in_alu[1:0]);

  // Next state, stall and misaligned decode; a late gnt/rvalid in idle falls through unused
  always_comb begin
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    launch     = 1'b0;
    capture    = 1'b0;
    timeout    = 1'b0;
    stall      = 1'b0;
    misaligned = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_op) begin
          if (bad_align) begin
            misaligned = 1'b1;
          end else begin
            launch  = 1'b1;
            stall   = 1'b1;
            tcnt_d  = '0;
            state_d = StReq;
          end
        end
      end
      StReq: begin
        stall  = 1'b1;
        tcnt_d = tcnt_q + TCNT_W'(1);
        if (dmem_gnt) begin
          if (is_store) begin
            state_d = StDone;
          end else if (dmem_rvalid) begin
            capture = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StWaitR;
          end
        end else if (tcnt_q == TCNT_LAST) begin
          timeout = 1'b1;
          state_d = StDone;
        end
      end
      StWaitR: begin
        stall  = 1'b1;
        tcnt_d = tcnt_q + TCNT_W'(1);
        if (dmem_rvalid) begin
          capture = 1'b1;
          state_d = StDone;
        end else if (tcnt_q == TCNT_LAST) begin
          timeout = 1'b1;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Store lane placement from access size and low address bits
  always_comb begin
    case (in_inst[13:12])
      2'b00: begin
        be_new    = 4'b0001 << in_alu[1:0];
        wdata_new = {4{in_rs2[7:0]}};
      end
      2'b01: begin
        be_new    = 4'b0011 << {in_alu[1], 1'b0};
        wdata_new = {2{in_rs2[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = in_rs2;
      end
    endcase
  end

  // FSM state, timeout counter and error pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      tcnt_q    <= '0;
      req_q     <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      req_q     <= (state_d == StReq);
      bus_err_q <= timeout;
    end
  end

  // Request attributes and access context, latched once at launch and held until the next one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      alo_q   <= '0;
      f3_q    <= '0;
    end else if (launch) begin
      we_q    <= is_store;
      addr_q  <= {in_alu[31:2], 2'b00};
      be_q    <= be_new;
      wdata_q <= wdata_new;
      alo_q   <= in_alu[1:0];
      f3_q    <= in_inst[14:12];
    end
  end

  // Load data capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
    end else if (capture) begin
      rdata_q <= dmem_rdata;
    end
  end

  mem_access_stage_load_extend u_load_extend (
    .rdata   (rdata_q),
    .addr_lo (alo_q),
    .funct3  (f3_q),
    .ext     (load_val)
  );

  // Writeback select; reserved code 3 falls back to the ALU result
  always_comb begin
    unique case (in_wbSel)
      WB_MEM:  mem_rd = load_val;
      WB_PC4:  mem_rd = in_pc + 32'd4;
      default: mem_rd = in_alu;
    endcase
  end

  assign mem_inst   = in_inst;
  assign mem_regWEn = in_valid & in_regWEn & ~misaligned & ~bus_err_q;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign bus_err    = bus_err_q;

endmodule
